// File: rtl/fetch_stage.sv
// fetch_stage: PC register, icache fetch handshake and IF/ID latch with stall/flush/halt.
// Optional macro FETCH_PERF_EN adds fetch_cnt/miss_cnt performance counters.
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [1:0]        PCSrc,
    input  logic [WORD_W-1:0] jump_addr,
    input  logic [WORD_W-1:0] jr_addr,
    input  logic [WORD_W-1:0] branch_addr,
    input  logic              stall,
    input  logic              flush,
    input  logic              halt,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_npc,
    output logic              ifid_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam logic [1:0] ADD4_DIAOSI   = 2'd0;
    localparam logic [1:0] JUMP_DIAOSI   = 2'd1;
    localparam logic [1:0] JR_DIAOSI     = 2'd2;
    localparam logic [1:0] BRANCH_DIAOSI = 2'd3;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT_ID = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] pc, pc_n;
    logic [WORD_W-1:0] held, held_n;
    logic [WORD_W-1:0] instr_n, npc_n;
    logic              valid_n;
    logic [WORD_W-1:0] pc_plus4, next_pc;
    logic              redirect;
    logic              loaded;

    assign pc_plus4 = pc + WORD_W'(4);
    assign redirect = (PCSrc != ADD4_DIAOSI) && !stall;
    assign iaddr    = pc;
    // Gated by nRST so the icache sees no request while reset is held.
    assign iREN     = nRST && (state == FETCH);

    always_comb begin
        case (PCSrc)
            JUMP_DIAOSI:   next_pc = jump_addr;
            JR_DIAOSI:     next_pc = jr_addr;
            BRANCH_DIAOSI: next_pc = branch_addr;
            default:       next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        held_n  = held;
        instr_n = ifid_instr;
        npc_n   = ifid_npc;
        valid_n = ifid_valid;
        loaded  = 1'b0;
        if (halt) begin
            state_n = HALTED;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit && !stall) begin
                        instr_n = iload;
                        npc_n   = pc_plus4;
                        valid_n = 1'b1;
                        loaded  = 1'b1;
                        pc_n    = next_pc;
                    end else if (ihit && stall) begin
                        held_n  = iload;
                        state_n = WAIT_ID;
                    end else if (!stall) begin
                        valid_n = 1'b0;
                        if (redirect) pc_n = next_pc;
                    end
                end
                WAIT_ID: begin
                    if (!stall) begin
                        state_n = FETCH;
                        // A redirect abandons the word captured during the stall.
                        if (redirect) begin
                            pc_n    = next_pc;
                            valid_n = 1'b0;
                        end else begin
                            instr_n = held;
                            npc_n   = pc_plus4;
                            valid_n = 1'b1;
                            loaded  = 1'b1;
                            pc_n    = pc_plus4;
                        end
                    end
                end
                HALTED:  state_n = HALTED;
                default: state_n = FETCH;
            endcase
            if (flush && (state != HALTED)) begin
                valid_n = 1'b0;
                instr_n = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            held       <= '0;
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            held       <= held_n;
            ifid_instr <= instr_n;
            ifid_npc   <= npc_n;
            ifid_valid <= valid_n;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt <= '0;
            miss_cnt  <= '0;
        end else if (state != HALTED) begin
            if (loaded && !flush && !halt) fetch_cnt <= fetch_cnt + 32'd1;
            if ((state == FETCH) && !ihit) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    logic unused_loaded;
    assign unused_loaded = loaded;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; expected IF/ID words are queued
// when a load is provoked and checked when the DUT presents a new live instruction.
`default_nettype none

module tb_fetch_stage;

    localparam logic [1:0] ADD4   = 2'd0;
    localparam logic [1:0] JUMP   = 2'd1;
    localparam logic [1:0] JR     = 2'd2;
    localparam logic [1:0] BRANCH = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  PCSrc;
    logic [31:0] jump_addr, jr_addr, branch_addr;
    logic        stall, flush, halt, ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr, ifid_instr, ifid_npc;
    logic        ifid_valid;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb[$];
    logic        mon_en = 1'b1;

    fetch_stage #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .PCSrc(PCSrc),
        .jump_addr(jump_addr), .jr_addr(jr_addr), .branch_addr(branch_addr),
        .stall(stall), .flush(flush), .halt(halt),
        .ihit(ihit), .iload(iload),
        .iREN(iREN), .iaddr(iaddr),
        .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] npc);
        sb.push_back({instr, npc});
    endtask

    task automatic drive(input logic h, input logic [31:0] ld, input logic st,
                         input logic fl, input logic [1:0] src);
        ihit  = h;
        iload = ld;
        stall = st;
        flush = fl;
        PCSrc = src;
        @(posedge CLK);
        #1;
    endtask

    // A live IF/ID after an unstalled, non-halted edge must be a fresh load.
    always begin
        logic s, en;
        logic [63:0] e;
        @(posedge CLK);
        s  = stall;
        en = mon_en && nRST && !halt;
        #3;
        if (en && !s && ifid_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", {31'b0, ifid_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_instr", ifid_instr, e[63:32]);
                check("sb_npc", ifid_npc, e[31:0]);
            end
        end
    end

    initial begin
        nRST = 1'b0; PCSrc = ADD4; stall = 0; flush = 0; halt = 0; ihit = 0; iload = '0;
        jump_addr = '0; jr_addr = '0; branch_addr = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_iren", {31'b0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_valid", {31'b0, ifid_valid}, 32'd0);
        check("rst_instr", ifid_instr, 32'h0);
        check("rst_npc", ifid_npc, 32'h0);
        nRST = 1'b1;
        #1;
        check("post_rst_iren", {31'b0, iREN}, 32'd1);

        // Back-to-back hits from PC 0.
        for (int i = 0; i < 4; i++) begin
            check("seq_iaddr", iaddr, 32'(4 * i));
            push(32'hA000_0000 + 32'(i), 32'(4 * (i + 1)));
            drive(1, 32'hA000_0000 + 32'(i), 0, 0, ADD4);
            check("seq_npc", ifid_npc, 32'(4 * (i + 1)));
        end

        // Three misses at 0x10 then a hit.
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'hDEAD_0000, 0, 0, ADD4);
            check("miss_iaddr", iaddr, 32'h10);
            check("miss_iren", {31'b0, iREN}, 32'd1);
            check("miss_valid", {31'b0, ifid_valid}, 32'd0);
        end
        push(32'hB000_0010, 32'h14);
        drive(1, 32'hB000_0010, 0, 0, ADD4);
        check("miss_hit_instr", ifid_instr, 32'hB000_0010);
        check("miss_hit_npc", ifid_npc, 32'h14);
        for (int i = 0; i < 3; i++) begin
            push(32'hB100_0000 + 32'(i), 32'h18 + 32'(4 * i));
            drive(1, 32'hB100_0000 + 32'(i), 0, 0, ADD4);
        end

        // Hit under stall at 0x20: captured word waits, IF/ID held.
        check("stall_pc_pre", iaddr, 32'h20);
        drive(1, 32'hC000_0020, 1, 0, ADD4);
        check("wait_iren", {31'b0, iREN}, 32'd0);
        check("wait_pc", iaddr, 32'h20);
        check("wait_hold_npc", ifid_npc, 32'h20);
        drive(0, 32'h0, 1, 0, ADD4);
        check("wait2_iren", {31'b0, iREN}, 32'd0);
        check("wait2_hold_instr", ifid_instr, 32'hB100_0002);
        push(32'hC000_0020, 32'h24);
        drive(0, 32'h0, 0, 0, ADD4);
        check("release_npc", ifid_npc, 32'h24);
        check("release_iaddr", iaddr, 32'h24);
        check("release_iren", {31'b0, iREN}, 32'd1);

        // Taken branch with flush; the same-cycle hit is squashed.
        branch_addr = 32'h100;
        drive(1, 32'hEEEE_0024, 0, 1, BRANCH);
        check("br_iaddr", iaddr, 32'h100);
        check("br_valid", {31'b0, ifid_valid}, 32'd0);
        check("br_instr", ifid_instr, 32'h0);

        // JR redirect while a miss is outstanding.
        drive(0, 32'h0, 0, 0, ADD4);
        jr_addr = 32'h40;
        drive(0, 32'hEEEE_0100, 0, 0, JR);
        check("jr_iaddr", iaddr, 32'h40);
        push(32'hD000_0040, 32'h44);
        drive(1, 32'hD000_0040, 0, 0, ADD4);

        // Jump out of WAIT_ID discards the held word.
        drive(1, 32'hEEEE_0044, 1, 0, ADD4);
        jump_addr = 32'h80;
        drive(0, 32'h0, 0, 0, JUMP);
        check("jwait_iaddr", iaddr, 32'h80);
        check("jwait_valid", {31'b0, ifid_valid}, 32'd0);

        // Stall and flush together: IF/ID cleared, PC held.
        drive(1, 32'hF000_0080, 1, 1, ADD4);
        check("sf_valid", {31'b0, ifid_valid}, 32'd0);
        check("sf_iaddr", iaddr, 32'h80);
        push(32'hF000_0080, 32'h84);
        drive(0, 32'h0, 0, 0, ADD4);
        check("sf_release_iaddr", iaddr, 32'h84);

        // PC+4 wrap at the top of the address space.
        jump_addr = 32'hFFFF_FFFC;
        drive(0, 32'h0, 0, 0, JUMP);
        check("wrap_pre", iaddr, 32'hFFFF_FFFC);
        push(32'h1234_5678, 32'h0);
        drive(1, 32'h1234_5678, 0, 0, ADD4);
        check("wrap_iaddr", iaddr, 32'h0);
        check("wrap_npc", ifid_npc, 32'h0);
        push(32'h2222_0000, 32'h4);
        drive(1, 32'h2222_0000, 0, 0, ADD4);

        // Halt at PC 4: fetching stops and nothing moves until reset.
        halt   = 1'b1;
        mon_en = 1'b0;
        drive(0, 32'h0, 0, 0, ADD4);
        check("halt_iren", {31'b0, iREN}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            drive(1, $urandom, 0, 1, JUMP);
            check("halt_pc", iaddr, 32'h4);
        end
        check("halt_iren_end", {31'b0, iREN}, 32'd0);
        check("halt_ifid_npc", ifid_npc, 32'h4);
        check("halt_ifid_instr", ifid_instr, 32'h2222_0000);

        nRST = 1'b0;
        halt = 1'b0;
        #1;
        check("halt_rst_pc", iaddr, 32'h0);
        check("halt_rst_valid", {31'b0, ifid_valid}, 32'd0);
        @(posedge CLK);
        #1;
        nRST   = 1'b1;
        mon_en = 1'b1;
        #1;
        check("resume_iren", {31'b0, iREN}, 32'd1);
        push(32'h3333_0000, 32'h4);
        drive(1, 32'h3333_0000, 0, 0, ADD4);
        check("resume_iaddr", iaddr, 32'h4);
        drive(0, 32'h0, 0, 0, ADD4);

        #5;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
